// File: rtl/data_cache_pkg.sv
// Shared types and geometry helpers for the direct-mapped data cache.
package data_cache_pkg;

  localparam int unsigned WORD_SIZE_DEF  = 16;
  localparam int unsigned LINE_WORDS_DEF = 4;
  localparam int unsigned NUM_LINES_DEF  = 4;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StWriteback = 2'd1,
    StFill      = 2'd2
  } state_e;

  // Tag width left over after the offset and index fields.
  function automatic int unsigned tag_bits(input int unsigned word_size,
                                           input int unsigned line_words,
                                           input int unsigned num_lines);
    return word_size - $clog2(line_words) - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/data_cache_line_array.sv
// Tag/valid/dirty/data storage: one combinational read port and synchronous
// word-merge and line-fill write ports, all addressed by the same index.
module cache_line_array
  import data_cache_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = WORD_SIZE_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned NUM_LINES  = NUM_LINES_DEF,
  localparam int unsigned OB        = $clog2(LINE_WORDS),
  localparam int unsigned IB        = $clog2(NUM_LINES),
  localparam int unsigned TB        = tag_bits(WORD_SIZE, LINE_WORDS, NUM_LINES),
  localparam int unsigned LINE_BITS = LINE_WORDS * WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [IB-1:0]        idx,
  input  logic [OB-1:0]        word_off,
  input  logic                 word_we,
  input  logic [WORD_SIZE-1:0] word_data,
  input  logic                 fill_we,
  input  logic [LINE_BITS-1:0] fill_line,
  input  logic [TB-1:0]        fill_tag,
  input  logic                 clean_we,
  output logic [LINE_BITS-1:0] line,
  output logic [TB-1:0]        tag,
  output logic                 valid,
  output logic                 dirty
);

  logic [LINE_BITS-1:0] data_q [NUM_LINES];
  logic [TB-1:0]        tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;

  // Status bits: the only storage cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end else if (clean_we) begin
      dirty_q[idx] <= 1'b0;
    end
  end

  // Data and tag arrays: a fill replaces the whole line, a store merges one word.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      data_q[idx] <= fill_line;
      tag_q[idx]  <= fill_tag;
    end else if (word_we) begin
      data_q[idx][word_off*WORD_SIZE +: WORD_SIZE] <= word_data;
    end
  end

  assign line  = data_q[idx];
  assign tag   = tag_q[idx];
  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate cache. Hits complete combinationally;
// misses stall via c_ready while the FSM writes back and refills the line.
module data_cache
  import data_cache_pkg::*;
#(
  parameter int unsigned WORD_SIZE  = WORD_SIZE_DEF,
  parameter int unsigned LINE_WORDS = LINE_WORDS_DEF,
  parameter int unsigned NUM_LINES  = NUM_LINES_DEF,
  localparam int unsigned OB        = $clog2(LINE_WORDS),
  localparam int unsigned IB        = $clog2(NUM_LINES),
  localparam int unsigned TB        = tag_bits(WORD_SIZE, LINE_WORDS, NUM_LINES),
  localparam int unsigned LINE_BITS = LINE_WORDS * WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 c_read,
  input  logic                 c_write,
  input  logic [WORD_SIZE-1:0] c_addr,
  input  logic [WORD_SIZE-1:0] c_wdata,
  output logic [WORD_SIZE-1:0] c_rdata,
  output logic                 c_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [LINE_BITS-1:0] mem_wline,
  input  logic [LINE_BITS-1:0] mem_rline,
  input  logic                 mem_ack,
  output logic [WORD_SIZE-1:0] hit_count,
  output logic [WORD_SIZE-1:0] miss_count
);

  state_e state_q, state_d;
  logic   replay_q, replay_d;
  logic [WORD_SIZE-1:0] hit_q, miss_q;
  logic   hit_inc, miss_inc;

  logic [OB-1:0] off;
  logic [IB-1:0] idx;
  logic [TB-1:0] req_tag;
  logic          req, hit;

  logic [LINE_BITS-1:0] line;
  logic [TB-1:0]        line_tag;
  logic                 line_valid, line_dirty;
  logic                 word_we, fill_we, clean_we;

  assign off     = c_addr[OB-1:0];
  assign idx     = c_addr[OB+IB-1:OB];
  assign req_tag = c_addr[WORD_SIZE-1:OB+IB];
  assign req     = c_read | c_write;
  assign hit     = line_valid && (line_tag == req_tag);

  cache_line_array #(
    .WORD_SIZE (WORD_SIZE),
    .LINE_WORDS(LINE_WORDS),
    .NUM_LINES (NUM_LINES)
  ) u_array (
    .clk      (clk),
    .reset_n  (reset_n),
    .idx      (idx),
    .word_off (off),
    .word_we  (word_we),
    .word_data(c_wdata),
    .fill_we  (fill_we),
    .fill_line(mem_rline),
    .fill_tag (req_tag),
    .clean_we (clean_we),
    .line     (line),
    .tag      (line_tag),
    .valid    (line_valid),
    .dirty    (line_dirty)
  );

  // Next state, datapath handshake and memory request decode.
  always_comb begin
    state_d   = state_q;
    replay_d  = replay_q;
    c_ready   = 1'b1;
    c_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wline = '0;
    word_we   = 1'b0;
    fill_we   = 1'b0;
    clean_we  = 1'b0;
    hit_inc   = 1'b0;
    miss_inc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The replay flag only covers the first IDLE cycle after a refill.
        replay_d = 1'b0;
        if (req) begin
          if (hit) begin
            if (c_read) c_rdata = line[off*WORD_SIZE +: WORD_SIZE];
            word_we = c_write;
            hit_inc = !replay_q;
          end else begin
            c_ready  = 1'b0;
            miss_inc = 1'b1;
            state_d  = (line_valid && line_dirty) ? StWriteback : StFill;
          end
        end
      end
      StWriteback: begin
        c_ready   = 1'b0;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {line_tag, idx, {OB{1'b0}}};
        mem_wline = line;
        if (mem_ack) begin
          clean_we = 1'b1;
          state_d  = StFill;
        end
      end
      StFill: begin
        c_ready  = 1'b0;
        mem_req  = 1'b1;
        mem_addr = {req_tag, idx, {OB{1'b0}}};
        if (mem_ack) begin
          fill_we  = 1'b1;
          replay_d = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, replay flag and wrapping performance counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      replay_q <= 1'b0;
      hit_q    <= '0;
      miss_q   <= '0;
    end else begin
      state_q  <= state_d;
      replay_q <= replay_d;
      if (hit_inc)  hit_q  <= hit_q + WORD_SIZE'(1);
      if (miss_inc) miss_q <= miss_q + WORD_SIZE'(1);
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule

// File: tb/tb_data_cache.sv
// Directed bench: a latency-L line memory model, a read-data scoreboard with
// an independent monitor, and direct checks of counters and memory traffic.
module tb_data_cache;

  localparam int Lat = 4;
  localparam logic [15:0] WA = 16'h0A0A, WB = 16'h0B0B, WC = 16'h0C0C, WD = 16'h0D0D;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        c_read, c_write;
  logic [15:0] c_addr, c_wdata, c_rdata;
  logic        c_ready;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [63:0] mem_wline, mem_rline;
  logic [15:0] hit_count, miss_count;

  data_cache #(.WORD_SIZE(16), .LINE_WORDS(4), .NUM_LINES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .c_read    (c_read),
    .c_write   (c_write),
    .c_addr    (c_addr),
    .c_wdata   (c_wdata),
    .c_rdata   (c_rdata),
    .c_ready   (c_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wline (mem_wline),
    .mem_rline (mem_rline),
    .mem_ack   (mem_ack),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [63:0] wline;
  } xfer_t;

  xfer_t       xlog[$];
  logic [15:0] exp_q[$];
  logic [63:0] mem [int];
  int          req_cycles = 0;
  int          total = 0;
  int          bad = 0;

  function automatic logic [63:0] mem_get(input int k);
    logic [15:0] b;
    if (mem.exists(k)) return mem[k];
    b = 16'(k * 4) ^ 16'h3C00;
    return {b + 16'd3, b + 16'd2, b + 16'd1, b};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Line memory: acks Lat cycles after a request is first seen; keeps
  // counting an abandoned transfer so its late ack still appears.
  initial begin : mem_model
    bit          busy = 0;
    int          cnt = 0;
    logic [15:0] cur_addr = '0;
    logic        cur_we = 0;
    logic [63:0] cur_wline = '0;
    mem[16'h0010 >> 2] = {WD, WC, WB, WA};
    mem[16'h0050 >> 2] = {16'h5003, 16'h5002, 16'h5001, 16'h5000};
    mem_ack   = 1'b0;
    mem_rline = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req) req_cycles++;
      if (busy) begin
        cnt++;
        if (cnt == Lat) begin
          if (cur_we) mem[int'(cur_addr >> 2)] = cur_wline;
          else mem_rline = mem_get(int'(cur_addr >> 2));
          mem_ack = 1'b1;
          busy    = 0;
        end
      end else if (mem_req) begin
        busy      = 1;
        cnt       = 0;
        cur_addr  = mem_addr;
        cur_we    = mem_we;
        cur_wline = mem_wline;
        xlog.push_back('{we: mem_we, addr: mem_addr, wline: mem_wline});
      end
    end
  end

  // Monitor: every completed pure read is compared against the scoreboard.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (c_ready && c_read && !c_write) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rdata_unexpected: got %0h want none", c_rdata);
        end else begin
          check("rdata", 64'(c_rdata), 64'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // Issues one access, waits for completion and returns the stall cycles.
  task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] exp, output int stall);
    if (rd && !wr) exp_q.push_back(exp);
    c_read  = rd;
    c_write = wr;
    c_addr  = a;
    c_wdata = wd;
    stall   = 0;
    forever begin
      @(negedge clk);
      if (c_ready) break;
      stall++;
      if (stall > 100) begin
        total++;
        bad++;
        $display("FAIL access_timeout: got stall>%0d want completion", stall);
        break;
      end
    end
    @(posedge clk);
    #2;
    c_read  = 1'b0;
    c_write = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin : stim
    int st;
    int base;
    int rc0;
    bit ack_seen;
    reset_n = 1'b0;
    c_read  = 1'b0;
    c_write = 1'b0;
    c_addr  = '0;
    c_wdata = '0;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_ready", 64'(c_ready), 64'd1);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_rdata", 64'(c_rdata), 64'd0);
    check("rst_hits", 64'(hit_count), 64'd0);
    check("rst_misses", 64'(miss_count), 64'd0);
    @(posedge clk);
    #2;

    // 1: clean read miss then same-line hit
    access(1'b1, 1'b0, 16'h0013, 16'h0, WD, st);
    check("t1_stall", 64'(st), 64'(Lat + 2));
    check("t1_misses", 64'(miss_count), 64'd1);
    check("t1_hits", 64'(hit_count), 64'd0);
    access(1'b1, 1'b0, 16'h0010, 16'h0, WA, st);
    check("t1_hit_stall", 64'(st), 64'd0);
    check("t1_hits2", 64'(hit_count), 64'd1);

    // 2: write miss allocates and merges, no writeback issued
    do_reset();
    base = xlog.size();
    access(1'b0, 1'b1, 16'h0011, 16'h1234, 16'h0, st);
    check("t2_stall", 64'(st), 64'(Lat + 2));
    access(1'b1, 1'b0, 16'h0011, 16'h0, 16'h1234, st);
    check("t2_xfers", 64'(xlog.size() - base), 64'd1);
    check("t2_fill_we", 64'(xlog[base].we), 64'd0);
    check("t2_fill_addr", 64'(xlog[base].addr), 64'h0010);
    check("t2_misses", 64'(miss_count), 64'd1);
    check("t2_hits", 64'(hit_count), 64'd1);

    // 3: conflicting read evicts the dirty line
    base = xlog.size();
    rc0  = req_cycles;
    access(1'b1, 1'b0, 16'h0051, 16'h0, 16'h5001, st);
    check("t3_stall", 64'(st), 64'(2 * Lat + 3));
    check("t3_req_cycles", 64'(req_cycles - rc0), 64'(2 * Lat + 2));
    check("t3_xfers", 64'(xlog.size() - base), 64'd2);
    check("t3_wb_we", 64'(xlog[base].we), 64'd1);
    check("t3_wb_addr", 64'(xlog[base].addr), 64'h0010);
    check("t3_wb_line", xlog[base].wline, {WD, WC, 16'h1234, WA});
    check("t3_fill_we", 64'(xlog[base+1].we), 64'd0);
    check("t3_fill_addr", 64'(xlog[base+1].addr), 64'h0050);
    check("t3_misses", 64'(miss_count), 64'd2);
    // Written-back data comes back from memory on the next clean miss
    access(1'b1, 1'b0, 16'h0011, 16'h0, 16'h1234, st);
    check("t3_refetch_stall", 64'(st), 64'(Lat + 2));
    check("t3_misses2", 64'(miss_count), 64'd3);

    // 4: reset during FILL abandons the transfer
    do_reset();
    c_read = 1'b1;
    c_addr = 16'h0013;
    repeat (3) @(posedge clk);
    #2;
    check("t4_in_fill", 64'(mem_req), 64'd1);
    reset_n = 1'b0;
    c_read  = 1'b0;
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(negedge clk);
    check("t4_req_dropped", 64'(mem_req), 64'd0);
    check("t4_ready", 64'(c_ready), 64'd1);
    check("t4_misses_cleared", 64'(miss_count), 64'd0);
    ack_seen = 0;
    for (int w = 0; w < 20; w++) begin
      if (mem_ack) begin
        ack_seen = 1;
        break;
      end
      @(negedge clk);
    end
    check("t4_late_ack_seen", 64'(ack_seen), 64'd1);
    @(posedge clk);
    #2;
    @(negedge clk);
    check("t4_idle_after_ack", 64'(mem_req), 64'd0);
    @(posedge clk);
    #2;
    access(1'b1, 1'b0, 16'h0013, 16'h0, WD, st);
    check("t4_miss_again", 64'(st), 64'(Lat + 2));
    check("t4_misses", 64'(miss_count), 64'd1);
    check("t4_hits", 64'(hit_count), 64'd0);

    // 5: read+write on a hit behaves as a write
    access(1'b1, 1'b1, 16'h0012, 16'h7777, 16'h0, st);
    check("t5_stall", 64'(st), 64'd0);
    check("t5_hits", 64'(hit_count), 64'd1);
    access(1'b1, 1'b0, 16'h0012, 16'h0, 16'h7777, st);
    check("t5_hits2", 64'(hit_count), 64'd2);
    base = xlog.size();
    access(1'b1, 1'b0, 16'h0052, 16'h0, 16'h5002, st);
    check("t5_wb_we", 64'(xlog[base].we), 64'd1);
    check("t5_wb_word", 64'(xlog[base].wline[47:32]), 64'h7777);
    check("t5_misses", 64'(miss_count), 64'd2);

    // 6: hit counter wraps
    c_write = 1'b1;
    c_addr  = 16'h0050;
    c_wdata = 16'hBEEF;
    repeat (65535 - 2) @(posedge clk);
    #2;
    check("t6_hits_max", 64'(hit_count), 64'hFFFF);
    @(posedge clk);
    #2;
    c_write = 1'b0;
    check("t6_hits_wrap", 64'(hit_count), 64'd0);
    check("t6_misses", 64'(miss_count), 64'd2);
    access(1'b1, 1'b0, 16'h0050, 16'h0, 16'hBEEF, st);
    check("t6_hits_after", 64'(hit_count), 64'd1);

    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
